pattern_scan_engine: RTL and testbench

- Hardware accelerator for bit-pattern counting over a byte string held in data memory. Generalises the program-3 computation in pattern width, string length, and base address, and adds a don't-care mask.
- Fetches LEN bytes from BASE through a read port, one byte per cycle, MSB-first. Produces three counts:
  - matches fully inside a byte;
  - bytes containing at least one match;
  - matches anywhere in the concatenated bit string (byte crossing allowed).
- Sits beside the core's data memory. Host or testbench drives start/done.

---
 rtl/pattern_scan_engine.sv | 187 ++++++++++++++++++
 tb/tb_pattern_scan_engine.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_engine.sv
// Counts PAT_W-bit masked pattern matches (in-byte, per-byte, byte-crossing) over LEN bytes read MSB-first from BASE.
// Done rises len+2 edges after the accepted start (1 edge for len=0); reads issue one per cycle with no backpressure.
module pattern_scan_engine #(
    parameter int PAT_W     = 5,
    parameter int MAX_BYTES = 32,
    parameter int ADDR_W    = 8,
    parameter int CNT_W     = 9
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [ADDR_W-1:0]              base,
    input  logic [$clog2(MAX_BYTES+1)-1:0] len,
    input  logic [PAT_W-1:0]               pat,
    input  logic [PAT_W-1:0]               mask,
    output logic                           rd_en,
    output logic [ADDR_W-1:0]              rd_addr,
    input  logic [7:0]                     rd_data,
    output logic                           busy,
    output logic                           done,
    output logic [CNT_W-1:0]               cnt_inbyte,
    output logic [CNT_W-1:0]               cnt_bytes,
    output logic [CNT_W-1:0]               cnt_cross
);

    localparam int LEN_W  = $clog2(MAX_BYTES+1);
    localparam int LAST_J = 8 - PAT_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [PAT_W-1:0]  mask_q, mask_d;
    logic [LEN_W-1:0]  i_q, i_d;
    logic [LEN_W-1:0]  r_q, r_d;
    logic              pend_q, pend_d;
    logic [6:0]        tail_q, tail_d;
    logic [CNT_W-1:0]  cnt_inbyte_q, cnt_inbyte_d;
    logic [CNT_W-1:0]  cnt_bytes_q, cnt_bytes_d;
    logic [CNT_W-1:0]  cnt_cross_q, cnt_cross_d;

    // Tail always keeps 7 bits so PAT_W=1 needs no zero-width vector; only
    // the low PAT_W-1 bits can ever fall inside a window.
    logic [14:0] cat;
    logic [7:0]  hit;
    logic [3:0]  n_inb;
    logic [3:0]  n_cross;
    logic        start_ok;

    assign cat = {tail_q, rd_data};

    always_comb begin
        hit = '0;
        for (int j = 0; j < 8; j++) begin
            hit[j] = (((PAT_W'(cat >> j)) ^ pat_q) & mask_q) == '0;
        end
    end

    // Window j ends at byte bit j; crossing windows count only once a previous byte exists.
    always_comb begin
        n_inb   = '0;
        n_cross = '0;
        for (int j = 0; j < 8; j++) begin
            if (hit[j] && (j <= LAST_J)) begin
                n_inb = n_inb + 4'd1;
            end
            if (hit[j] && ((j <= LAST_J) || (r_q != '0))) begin
                n_cross = n_cross + 4'd1;
            end
        end
    end

    assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        len_d        = len_q;
        pat_d        = pat_q;
        mask_d       = mask_q;
        i_d          = i_q;
        r_d          = r_q;
        pend_d       = 1'b0;
        tail_d       = tail_q;
        cnt_inbyte_d = cnt_inbyte_q;
        cnt_bytes_d  = cnt_bytes_q;
        cnt_cross_d  = cnt_cross_q;
        rd_en        = 1'b0;
        rd_addr      = '0;
        busy         = 1'b0;
        done         = 1'b0;

        // rd_data carries the byte requested on the previous cycle.
        if (pend_q) begin
            cnt_inbyte_d = cnt_inbyte_q + CNT_W'(n_inb);
            cnt_bytes_d  = cnt_bytes_q + CNT_W'(n_inb != '0);
            cnt_cross_d  = cnt_cross_q + CNT_W'(n_cross);
            tail_d       = rd_data[6:0];
            r_d          = r_q + LEN_W'(1);
        end

        case (state_q)
            S_IDLE: begin
            end
            S_RUN: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                rd_addr = base_q + ADDR_W'(i_q);
                pend_d  = 1'b1;
                i_d     = i_q + LEN_W'(1);
                if (i_q == len_q - LEN_W'(1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (r_q == len_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An empty scan passes through DRAIN so done still lands one edge later.
        if (start_ok) begin
            base_d       = base;
            len_d        = len;
            pat_d        = pat;
            mask_d       = mask;
            i_d          = '0;
            r_d          = '0;
            pend_d       = 1'b0;
            tail_d       = '0;
            cnt_inbyte_d = '0;
            cnt_bytes_d  = '0;
            cnt_cross_d  = '0;
            state_d      = (len == '0) ? S_DRAIN : S_RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            len_q        <= '0;
            pat_q        <= '0;
            mask_q       <= '0;
            i_q          <= '0;
            r_q          <= '0;
            pend_q       <= 1'b0;
            tail_q       <= '0;
            cnt_inbyte_q <= '0;
            cnt_bytes_q  <= '0;
            cnt_cross_q  <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            len_q        <= len_d;
            pat_q        <= pat_d;
            mask_q       <= mask_d;
            i_q          <= i_d;
            r_q          <= r_d;
            pend_q       <= pend_d;
            tail_q       <= tail_d;
            cnt_inbyte_q <= cnt_inbyte_d;
            cnt_bytes_q  <= cnt_bytes_d;
            cnt_cross_q  <= cnt_cross_d;
        end
    end

    assign cnt_inbyte = cnt_inbyte_q;
    assign cnt_bytes  = cnt_bytes_q;
    assign cnt_cross  = cnt_cross_q;

endmodule

// File: tb/tb_pattern_scan_engine.sv
// Bench for pattern_scan_engine: a memory model answers reads, and a bit-string reference model supplies expected counts.
module tb_pattern_scan_engine;

    localparam int PAT_W     = 5;
    localparam int MAX_BYTES = 32;
    localparam int ADDR_W    = 8;
    localparam int CNT_W     = 9;
    localparam int LEN_W     = $clog2(MAX_BYTES+1);

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len;
    logic [PAT_W-1:0]  pat;
    logic [PAT_W-1:0]  mask;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  cnt_inbyte;
    logic [CNT_W-1:0]  cnt_bytes;
    logic [CNT_W-1:0]  cnt_cross;

    logic [7:0] mem [0:255];
    logic [7:0] addr_log[$];
    int         rd_cnt = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    pattern_scan_engine #(
        .PAT_W(PAT_W), .MAX_BYTES(MAX_BYTES), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base(base), .len(len),
        .pat(pat), .mask(mask), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy), .done(done),
        .cnt_inbyte(cnt_inbyte), .cnt_bytes(cnt_bytes), .cnt_cross(cnt_cross)
    );

    // Synchronous read port: data valid the cycle after rd_en, garbage otherwise.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
            rd_cnt  <= rd_cnt + 1;
            addr_log.push_back(rd_addr);
        end else begin
            rd_data <= 8'($urandom);
        end
    end

    function automatic int window_at(input bit s[$], input int pos);
        int w = 0;
        for (int t = 0; t < PAT_W; t++) w = (w << 1) | int'(s[pos + t]);
        return w;
    endfunction

    // Reference: flatten the bytes into one MSB-first bit string and slide a window over it.
    function automatic void ref_counts(input int b, input int l, input logic [PAT_W-1:0] p,
                                       input logic [PAT_W-1:0] m,
                                       output int ib, output int nb, output int cr);
        bit         s[$];
        logic [7:0] v;
        int         h;
        ib = 0; nb = 0; cr = 0;
        for (int k = 0; k < l; k++) begin
            v = mem[(b + k) % 256];
            for (int t = 7; t >= 0; t--) s.push_back(v[t]);
        end
        for (int pos = 0; pos + PAT_W <= 8 * l; pos++)
            if (((window_at(s, pos) ^ int'(p)) & int'(m)) == 0) cr++;
        for (int k = 0; k < l; k++) begin
            h = 0;
            for (int off = 0; off <= 8 - PAT_W; off++)
                if (((window_at(s, 8 * k + off) ^ int'(p)) & int'(m)) == 0) h++;
            ib += h;
            if (h > 0) nb++;
        end
    endfunction

    task automatic fill_mem(input int mode);
        logic [7:0] pick [5];
        pick[0] = 8'h00; pick[1] = 8'hFF; pick[2] = 8'h55; pick[3] = 8'hAA; pick[4] = 8'h1F;
        for (int a = 0; a < 256; a++)
            mem[a] = (mode == 0) ? 8'($urandom) : pick[$urandom_range(0, 4)];
    endtask

    task automatic start_scan(input logic [7:0] b, input int l, input logic [PAT_W-1:0] p,
                              input logic [PAT_W-1:0] m);
        @(negedge clk);
        base = b; len = LEN_W'(l); pat = p; mask = m; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; base = '0; len = '0; pat = '0; mask = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rd_en, busy, done} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl got %b want 000", {rd_en, busy, done});
        end
        checks++;
        if (rd_addr !== '0) begin errors++; $display("FAIL reset_addr got %h want 00", rd_addr); end
        checks++;
        if ({cnt_inbyte, cnt_bytes, cnt_cross} !== '0) begin
            errors++; $display("FAIL reset_cnt got %0d %0d %0d want 0 0 0", cnt_inbyte, cnt_bytes, cnt_cross);
        end
        @(negedge clk) reset = 1'b1;
    endtask

    // Fixed cases with hand-derived answers: zeros, 0x55, boundary-only match, mask=0.
    task automatic test_fixed;
        int exp [4][3];
        int lens [4];
        logic [PAT_W-1:0] pats [4];
        logic [PAT_W-1:0] masks [4];
        int n;
        exp[0] = '{128, 32, 252}; exp[1] = '{64, 32, 126}; exp[2] = '{0, 0, 1}; exp[3] = '{12, 3, 20};
        lens = '{32, 32, 2, 3};
        pats = '{5'b00000, 5'b10101, 5'b11111, 5'($urandom)};
        masks = '{5'b11111, 5'b11111, 5'b11111, 5'b00000};
        for (int c = 0; c < 4; c++) begin
            for (int a = 0; a < 256; a++) mem[a] = (c == 0) ? 8'h00 : (c == 1) ? 8'h55 : 8'($urandom);
            if (c == 2) begin mem[8'h40] = 8'h07; mem[8'h41] = 8'hC0; end
            start_scan(8'h40, lens[c], pats[c], masks[c]);
            wait_done(n);
            checks++;
            if (n != lens[c] + 2) begin errors++; $display("FAIL fixed%0d_latency got %0d want %0d", c, n, lens[c] + 2); end
            checks++;
            if (int'(cnt_inbyte) != exp[c][0]) begin errors++; $display("FAIL fixed%0d_inbyte got %0d want %0d", c, cnt_inbyte, exp[c][0]); end
            checks++;
            if (int'(cnt_bytes) != exp[c][1]) begin errors++; $display("FAIL fixed%0d_bytes got %0d want %0d", c, cnt_bytes, exp[c][1]); end
            checks++;
            if (int'(cnt_cross) != exp[c][2]) begin errors++; $display("FAIL fixed%0d_cross got %0d want %0d", c, cnt_cross, exp[c][2]); end
        end
    endtask

    task automatic test_len0;
        int n, rc0;
        rc0 = rd_cnt;
        start_scan(8'h20, 0, 5'b00000, 5'b00000);
        wait_done(n);
        checks++;
        if (n != 1) begin errors++; $display("FAIL len0_latency got %0d want 1", n); end
        checks++;
        if ({cnt_inbyte, cnt_bytes, cnt_cross} !== '0) begin
            errors++; $display("FAIL len0_cnt got %0d %0d %0d want 0 0 0", cnt_inbyte, cnt_bytes, cnt_cross);
        end
        checks++;
        if (rd_cnt != rc0) begin errors++; $display("FAIL len0_reads got %0d want 0", rd_cnt - rc0); end
    endtask

    task automatic test_wrap;
        int n, idx, ib, nb, cr;
        logic [7:0] want [4];
        want = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        fill_mem(1);
        idx = addr_log.size();
        start_scan(8'hFE, 4, 5'b11111, 5'b11011);
        wait_done(n);
        ref_counts(8'hFE, 4, 5'b11111, 5'b11011, ib, nb, cr);
        checks++;
        if (addr_log.size() - idx != 4) begin errors++; $display("FAIL wrap_nreads got %0d want 4", addr_log.size() - idx); end
        for (int k = 0; k < 4 && idx + k < addr_log.size(); k++) begin
            checks++;
            if (addr_log[idx + k] !== want[k]) begin errors++; $display("FAIL wrap_addr%0d got %h want %h", k, addr_log[idx + k], want[k]); end
        end
        checks++;
        if (int'(cnt_cross) != cr || int'(cnt_inbyte) != ib) begin
            errors++; $display("FAIL wrap_cnt got %0d/%0d want %0d/%0d", cnt_inbyte, cnt_cross, ib, cr);
        end
    endtask

    task automatic test_random;
        int n, l, ib, nb, cr;
        logic [7:0] b;
        logic [PAT_W-1:0] p, m;
        for (int it = 0; it < 24; it++) begin
            fill_mem(it % 2);
            b = 8'($urandom);
            l = $urandom_range(1, MAX_BYTES);
            p = PAT_W'($urandom);
            m = $urandom_range(0, 1) ? '1 : PAT_W'($urandom);
            start_scan(b, l, p, m);
            wait_done(n);
            ref_counts(b, l, p, m, ib, nb, cr);
            checks++;
            if (n != l + 2) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", it, n, l + 2); end
            checks++;
            if (int'(cnt_inbyte) != ib || int'(cnt_bytes) != nb || int'(cnt_cross) != cr) begin
                errors++;
                $display("FAIL rnd%0d_cnt got %0d %0d %0d want %0d %0d %0d", it, cnt_inbyte, cnt_bytes, cnt_cross, ib, nb, cr);
            end
        end
    endtask

    task automatic test_start_ignored;
        int n, ib, nb, cr;
        fill_mem(1);
        start_scan(8'h30, 12, 5'b01010, 5'b11111);
        repeat (3) @(posedge clk);
        @(negedge clk);
        base = 8'h90; len = LEN_W'(3); pat = 5'b11111; mask = 5'b00000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(n);
        ref_counts(8'h30, 12, 5'b01010, 5'b11111, ib, nb, cr);
        checks++;
        if (n + 4 != 14) begin errors++; $display("FAIL ignored_latency got %0d want 14", n + 4); end
        checks++;
        if (int'(cnt_inbyte) != ib || int'(cnt_bytes) != nb || int'(cnt_cross) != cr) begin
            errors++; $display("FAIL ignored_cnt got %0d %0d %0d want %0d %0d %0d", cnt_inbyte, cnt_bytes, cnt_cross, ib, nb, cr);
        end
    endtask

    task automatic test_reset_mid;
        int n, ib, nb, cr;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        start_scan(8'h00, 20, 5'b00000, 5'b11111);
        repeat (6) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        #1;
        checks++;
        if ({rd_en, busy, done} !== 3'b000 || rd_addr !== '0) begin
            errors++; $display("FAIL midreset_ctrl got %b addr %h want 000 addr 00", {rd_en, busy, done}, rd_addr);
        end
        checks++;
        if ({cnt_inbyte, cnt_bytes, cnt_cross} !== '0) begin
            errors++; $display("FAIL midreset_cnt got %0d %0d %0d want 0 0 0", cnt_inbyte, cnt_bytes, cnt_cross);
        end
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done} !== 2'b00) begin errors++; $display("FAIL midreset_idle got %b want 00", {busy, done}); end
        fill_mem(0);
        start_scan(8'h80, 7, 5'b10011, 5'b11101);
        wait_done(n);
        ref_counts(8'h80, 7, 5'b10011, 5'b11101, ib, nb, cr);
        checks++;
        if (n != 9 || int'(cnt_inbyte) != ib || int'(cnt_bytes) != nb || int'(cnt_cross) != cr) begin
            errors++; $display("FAIL midreset_rescan got %0d %0d %0d lat %0d want %0d %0d %0d lat 9", cnt_inbyte, cnt_bytes, cnt_cross, n, ib, nb, cr);
        end
    endtask

    task automatic test_back_to_back;
        int n, ib, nb, cr;
        for (int a = 0; a < 256; a++) mem[a] = 8'hFF;
        start_scan(8'h00, 10, 5'b11111, 5'b11111);
        wait_done(n);
        checks++;
        if (int'(cnt_cross) != 76) begin errors++; $display("FAIL b2b_first got %0d want 76", cnt_cross); end
        fill_mem(1);
        start_scan(8'hC0, 9, 5'b00101, 5'b10111);
        checks++;
        if (done !== 1'b0 || cnt_cross !== '0 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_restart got done %b busy %b cross %0d want 0 1 0", done, busy, cnt_cross);
        end
        wait_done(n);
        ref_counts(8'hC0, 9, 5'b00101, 5'b10111, ib, nb, cr);
        checks++;
        if (n != 11 || int'(cnt_inbyte) != ib || int'(cnt_bytes) != nb || int'(cnt_cross) != cr) begin
            errors++; $display("FAIL b2b_second got %0d %0d %0d lat %0d want %0d %0d %0d lat 11", cnt_inbyte, cnt_bytes, cnt_cross, n, ib, nb, cr);
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_len0();
        test_wrap();
        test_random();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
